// File: rtl/logic_avalon_mm_modport_if.sv
// Avalon-MM bus bundle shared by both sides of the pipeline bridge.
// The master modport drives commands; the slave modport drives responses and waitrequest.
interface logic_avalon_mm_modport_if #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
);
  logic                       read;
  logic                       write;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [8*DATA_BYTES-1:0]    writedata;
  logic [DATA_BYTES-1:0]      byteenable;
  logic                       waitrequest;
  logic [8*DATA_BYTES-1:0]    readdata;
  logic                       readdatavalid;
  logic                       writeresponsevalid;
  logic [1:0]                 response;

  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
endinterface

// File: rtl/logic_avalon_mm_modport.sv
// Avalon-MM pipeline bridge: registered two-entry skid buffer on commands, registered responses.
// Optional macro LOGIC_AVALON_MM_MODPORT_WRITE_RESPONSE_EN enables the write-response path.
module logic_avalon_mm_modport #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  logic_avalon_mm_modport_if.slave    s,
  logic_avalon_mm_modport_if.master   m
);
  localparam int DW = 8 * DATA_BYTES;

  if (DATA_BYTES < 1 || DATA_BYTES > 128 || (DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_bad_bytes
    $error("DATA_BYTES must be a power of 2 in 1..128");
  end
  if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > 64) begin : g_bad_addr
    $error("ADDRESS_WIDTH must be in 1..64");
  end

  typedef struct packed {
    logic                     rd;
    logic                     wr;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DW-1:0]            wdata;
    logic [DATA_BYTES-1:0]    be;
  } cmd_t;

  cmd_t out_q, out_d, skid_q, skid_d, in_cmd;
  logic skid_full_q, skid_full_d;
  logic wait_q;
  logic out_full, up_acc, dn_acc;

  // Simultaneous read+write is forwarded as a write only.
  always_comb begin
    in_cmd       = '0;
    in_cmd.rd    = s.read & ~s.write;
    in_cmd.wr    = s.write;
    in_cmd.addr  = s.address;
    in_cmd.wdata = s.writedata;
    in_cmd.be    = s.byteenable;
  end

  assign out_full = out_q.rd | out_q.wr;
  assign up_acc   = (s.read | s.write) & ~wait_q;
  assign dn_acc   = out_full & ~m.waitrequest;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (dn_acc) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end else begin
        out_d.rd = 1'b0;
        out_d.wr = 1'b0;
      end
    end
    // Payload fields stay put when OUT empties so m_* only moves on a new load.
    if (up_acc) begin
      if ((!out_full || dn_acc) && !skid_full_q) begin
        out_d = in_cmd;
      end else begin
        skid_d      = in_cmd;
        skid_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      wait_q      <= 1'b1;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      wait_q      <= skid_full_d;
    end
  end

  assign s.waitrequest = wait_q;
  assign m.read        = out_q.rd;
  assign m.write       = out_q.wr;
  assign m.address     = out_q.addr;
  assign m.writedata   = out_q.wdata;
  assign m.byteenable  = out_q.be;

  logic          rdv_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    resp_q;
  logic          resp_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      rdv_q <= m.readdatavalid;
      if (m.readdatavalid) rdata_q <= m.readdata;
      if (resp_load)       resp_q  <= m.response;
    end
  end

`ifdef LOGIC_AVALON_MM_MODPORT_WRITE_RESPONSE_EN
  logic wrv_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrv_q <= 1'b0;
    else          wrv_q <= m.writeresponsevalid;
  end
  assign resp_load            = m.readdatavalid | m.writeresponsevalid;
  assign s.writeresponsevalid = wrv_q;
`else
  logic unused_wrv;
  assign unused_wrv           = m.writeresponsevalid;
  assign resp_load            = m.readdatavalid;
  assign s.writeresponsevalid = 1'b0;
`endif

  assign s.readdata      = rdata_q;
  assign s.readdatavalid = rdv_q;
  assign s.response      = resp_q;
endmodule

// File: tb/tb_logic_avalon_mm_modport.sv
// Directed self-checking bench for the Avalon-MM pipeline bridge.
module tb_logic_avalon_mm_modport;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic_avalon_mm_modport_if #(.DATA_BYTES(4), .ADDRESS_WIDTH(1)) up ();
  logic_avalon_mm_modport_if #(.DATA_BYTES(4), .ADDRESS_WIDTH(1)) dn ();

  logic_avalon_mm_modport #(.DATA_BYTES(4), .ADDRESS_WIDTH(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (up),
    .m       (dn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic rd, input logic wr, input logic a,
                           input logic [31:0] d, input logic [3:0] be);
    up.read       = rd;
    up.write      = wr;
    up.address    = a;
    up.writedata  = d;
    up.byteenable = be;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    drive_cmd(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    dn.waitrequest        = 1'b0;
    dn.readdata           = '0;
    dn.readdatavalid      = 1'b0;
    dn.writeresponsevalid = 1'b0;
    dn.response           = 2'b00;

    #12;
    check("rst_wait", up.waitrequest, 1);
    check("rst_m_read", dn.read, 0);
    check("rst_m_write", dn.write, 0);
    check("rst_rdv", up.readdatavalid, 0);
    check("rst_rdata", up.readdata, 0);
    reset_n = 1'b1;
    tick;
    check("rel_wait", up.waitrequest, 0);

    // single write
    drive_cmd(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF);
    tick;
    drive_cmd(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    check("wr_m_write", dn.write, 1);
    check("wr_m_read", dn.read, 0);
    check("wr_addr", dn.address, 1);
    check("wr_data", dn.writedata, 32'hDEADBEEF);
    check("wr_be", dn.byteenable, 4'hF);
    tick;
    check("wr_once", dn.write, 0);

    // single read, response returned two cycles later
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h0, 4'hF);
    tick;
    drive_cmd(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    check("rd_m_read", dn.read, 1);
    check("rd_addr", dn.address, 0);
    tick;
    check("rd_once", dn.read, 0);
    dn.readdatavalid = 1'b1;
    dn.readdata      = 32'h12345678;
    dn.response      = 2'b00;
    tick;
    dn.readdatavalid = 1'b0;
    dn.readdata      = 32'hFFFFFFFF;
    check("rd_rdv", up.readdatavalid, 1);
    check("rd_rdata", up.readdata, 32'h12345678);
    check("rd_resp", up.response, 0);
    tick;
    check("rd_rdv_clr", up.readdatavalid, 0);
    check("rd_rdata_hold", up.readdata, 32'h12345678);

    // stall: A to OUT, B to SKID, C refused until drained
    dn.waitrequest = 1'b1;
    drive_cmd(1'b0, 1'b1, 1'b0, 32'hAAAA0001, 4'h1);
    tick;
    check("st_a_out", dn.writedata, 32'hAAAA0001);
    check("st_wait0", up.waitrequest, 0);
    drive_cmd(1'b0, 1'b1, 1'b1, 32'hBBBB0002, 4'h3);
    tick;
    check("st_wait1", up.waitrequest, 1);
    check("st_a_hold", dn.writedata, 32'hAAAA0001);
    drive_cmd(1'b1, 1'b1, 1'b0, 32'hCCCC0003, 4'h7);
    tick;
    check("st_wait_c", up.waitrequest, 1);
    check("st_a_hold2", dn.writedata, 32'hAAAA0001);
    check("st_a_be", dn.byteenable, 4'h1);
    dn.waitrequest = 1'b0;
    tick;
    check("st_b_out", dn.writedata, 32'hBBBB0002);
    check("st_b_addr", dn.address, 1);
    check("st_wait_drain", up.waitrequest, 0);
    tick;
    drive_cmd(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    check("st_c_out", dn.writedata, 32'hCCCC0003);
    check("st_c_write", dn.write, 1);
    check("st_c_noread", dn.read, 0);
    tick;
    check("st_empty", dn.write, 0);

    // eight back-to-back reads, slave answers one cycle after each command
    for (int i = 0; i < 8; i++) begin
      drive_cmd(1'b1, 1'b0, i[0], 32'h0, 4'hF);
      tick;
      check("b2b_m_read", dn.read, 1);
      check("b2b_addr", dn.address, i[0]);
      check("b2b_wait", up.waitrequest, 0);
      if (i > 0) begin
        check("b2b_rdv", up.readdatavalid, 1);
        check("b2b_rdata", up.readdata, 32'h100 + i - 1);
      end
      dn.readdatavalid = 1'b1;
      dn.readdata      = 32'h100 + i;
    end
    drive_cmd(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    tick;
    dn.readdatavalid = 1'b0;
    check("b2b_last", up.readdata, 32'h107);
    check("b2b_done", dn.read, 0);

    // reset with OUT and SKID both full
    dn.waitrequest = 1'b1;
    drive_cmd(1'b1, 1'b0, 1'b0, 32'h0, 4'hF);
    tick;
    drive_cmd(1'b1, 1'b0, 1'b1, 32'h0, 4'hF);
    tick;
    check("mr_full", up.waitrequest, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_read", dn.read, 0);
    check("mr_write", dn.write, 0);
    check("mr_wait", up.waitrequest, 1);
    drive_cmd(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    dn.waitrequest = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick;
    check("mr_wait_rel", up.waitrequest, 0);
    check("mr_no_stale", dn.read, 0);
    tick;
    check("mr_no_stale2", dn.read | dn.write, 0);

    // write response
    dn.writeresponsevalid = 1'b1;
    dn.response           = 2'b10;
    tick;
    dn.writeresponsevalid = 1'b0;
    dn.response           = 2'b00;
`ifdef LOGIC_AVALON_MM_MODPORT_WRITE_RESPONSE_EN
    check("wresp_valid", up.writeresponsevalid, 1);
    check("wresp_code", up.response, 2'b10);
`else
    check("wresp_valid", up.writeresponsevalid, 0);
    check("wresp_code", up.response, 2'b00);
`endif
    tick;
    check("wresp_clr", up.writeresponsevalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
